// File: rtl/tcpip_tx_sched_pkg.sv
// Shared constants and encodings for the TX scheduler: ethertypes, grant selects, FSM states.
package tcpip_tx_sched_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

  typedef enum logic [1:0] {
    TX_SEL_NONE = 2'b00,
    TX_SEL_ARP  = 2'b01,
    TX_SEL_IP   = 2'b10,
    TX_SEL_UDP  = 2'b11
  } tx_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/tcpip_tx_arb.sv
// Combinational winner select: ARP has strict priority, IP and UDP alternate via last_ip.
module tcpip_tx_arb
  import tcpip_tx_sched_pkg::*;
(
  input  logic    arp_pend,
  input  logic    ip_pend,
  input  logic    udp_tx_req,
  input  logic    last_ip,
  output tx_sel_e sel,
  output logic    grant_valid
);

  always_comb begin
    sel = TX_SEL_NONE;
    if (arp_pend)
      sel = TX_SEL_ARP;
    else if (ip_pend && udp_tx_req)
      sel = last_ip ? TX_SEL_UDP : TX_SEL_IP;
    else if (ip_pend)
      sel = TX_SEL_IP;
    else if (udp_tx_req)
      sel = TX_SEL_UDP;
  end

  assign grant_valid = arp_pend | ip_pend | udp_tx_req;

endmodule

// File: rtl/tcpip_tx_sched.sv
// Shares the MAC TX engine between ARP replies, IPv4 replies and user UDP sends,
// with an inter-frame gap after every frame and a watchdog on hung transfers.
module tcpip_tx_sched
  import tcpip_tx_sched_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int TX_TIMEOUT = 4095
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        ip_pkt_end,
  input  logic [15:0] ip_prot_type,
  input  logic        udp_tx_req,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [1:0]  tx_sel,
  output logic        udp_tx_ack,
  output logic        tx_abort,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TX_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  state_e           state;
  tx_sel_e          sel_q;
  tx_sel_e          win_sel;
  logic             grant_valid;
  logic             arp_pend, ip_pend, last_ip;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant, arp_set, ip_set, arp_clr, ip_clr, drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  tcpip_tx_arb u_arb (
    .arp_pend    (arp_pend),
    .ip_pend     (ip_pend),
    .udp_tx_req  (udp_tx_req),
    .last_ip     (last_ip),
    .sel         (win_sel),
    .grant_valid (grant_valid)
  );

  assign grant   = (state == ST_IDLE) && grant_valid;
  assign arp_set = ip_pkt_end && (ip_prot_type == ETH_TYPE_ARP);
  assign ip_set  = ip_pkt_end && (ip_prot_type == ETH_TYPE_IPV4);
  assign arp_clr = grant && (win_sel == TX_SEL_ARP);
  assign ip_clr  = grant && (win_sel == TX_SEL_IP);
  // A new request arriving on the grant cycle is kept, not counted as lost.
  assign drop    = (arp_set && arp_pend && !arp_clr) || (ip_set && ip_pend && !ip_clr);
  assign tx_sel  = sel_q;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_pend <= 1'b0;
      ip_pend  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      arp_pend <= arp_set | (arp_pend & ~arp_clr);
      ip_pend  <= ip_set  | (ip_pend  & ~ip_clr);
      if (drop)
        drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel_q      <= TX_SEL_NONE;
      tx_start   <= 1'b0;
      udp_tx_ack <= 1'b0;
      tx_abort   <= 1'b0;
      busy       <= 1'b0;
      last_ip    <= 1'b0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      tx_start   <= 1'b0;
      udp_tx_ack <= 1'b0;
      tx_abort   <= 1'b0;
      case (state)
        ST_IDLE: if (grant_valid) begin
          state      <= ST_START;
          sel_q      <= win_sel;
          tx_start   <= 1'b1;
          udp_tx_ack <= (win_sel == TX_SEL_UDP);
          busy       <= 1'b1;
          if (win_sel == TX_SEL_IP)
            last_ip <= 1'b1;
          else if (win_sel == TX_SEL_UDP)
            last_ip <= 1'b0;
        end
        ST_START: begin
          state  <= ST_BUSY;
          to_cnt <= '0;
        end
        // Completion takes precedence over a coincident timeout.
        ST_BUSY: if (tx_done) begin
          state   <= ST_GAP;
          sel_q   <= TX_SEL_NONE;
          gap_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
          state    <= ST_GAP;
          sel_q    <= TX_SEL_NONE;
          tx_abort <= 1'b1;
          gap_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        ST_GAP: if (gap_cnt == GAP_LAST) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcpip_tx_sched.sv
// Bench for tcpip_tx_sched: directed scenarios then random traffic, every cycle
// compared against a timestamp-based model of the scheduling rules.
module tb_tcpip_tx_sched;

  localparam int IFG = 12;
  localparam int TO  = 16;

  logic        rx_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ip_pkt_end = 1'b0;
  logic [15:0] ip_prot_type = 16'h0000;
  logic        udp_tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start, udp_tx_ack, tx_abort, busy;
  logic [1:0]  tx_sel;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 rx_clk = ~rx_clk;

  tcpip_tx_sched #(.IFG_CYCLES(IFG), .TX_TIMEOUT(TO)) dut (
    .rx_clk       (rx_clk),
    .rst_n        (rst_n),
    .ip_pkt_end   (ip_pkt_end),
    .ip_prot_type (ip_prot_type),
    .udp_tx_req   (udp_tx_req),
    .tx_done      (tx_done),
    .tx_start     (tx_start),
    .tx_sel       (tx_sel),
    .udp_tx_ack   (udp_tx_ack),
    .tx_abort     (tx_abort),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  // Model: the engine is described by when the current frame started and
  // the cycle at which the scheduler may accept a new grant again.
  int cyc = 0, m_idle_at = 0, m_t0 = 0, m_drops = 0, m_sel = 0;
  bit m_arp = 0, m_ip = 0, m_last_ip = 0, m_open = 0;
  bit e_start = 0, e_ack = 0, e_abort = 0, e_busy = 0;
  int e_sel = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic check_all();
    chk("tx_start", 16'(tx_start), 16'(e_start));
    chk("tx_sel", 16'(tx_sel), 16'(e_sel));
    chk("udp_tx_ack", 16'(udp_tx_ack), 16'(e_ack));
    chk("tx_abort", 16'(tx_abort), 16'(e_abort));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("drop_cnt", 16'(drop_cnt), 16'(m_drops));
  endtask

  function automatic bit model_idle();
    return !m_open && !e_start && (cyc >= m_idle_at);
  endfunction

  task automatic step();
    int w;
    bit aset, iset, nab;
    w = 0;
    nab = 0;
    if (model_idle()) begin
      if (m_arp) w = 1;
      else if (m_ip && udp_tx_req) w = m_last_ip ? 3 : 2;
      else if (m_ip) w = 2;
      else if (udp_tx_req) w = 3;
    end
    if (w == 2) m_last_ip = 1;
    if (w == 3) m_last_ip = 0;
    aset = ip_pkt_end && (ip_prot_type == 16'h0806);
    iset = ip_pkt_end && (ip_prot_type == 16'h0800);
    if ((aset && m_arp && w != 1) || (iset && m_ip && w != 2))
      m_drops = (m_drops < 255) ? m_drops + 1 : 255;
    m_arp = aset || (m_arp && w != 1);
    m_ip  = iset || (m_ip && w != 2);
    if (e_start) begin
      m_open = 1;
      m_t0 = cyc + 1;
    end else if (m_open) begin
      if (tx_done) begin
        m_open = 0;
        m_idle_at = cyc + 1 + IFG;
      end else if (cyc - m_t0 == TO - 1) begin
        m_open = 0;
        nab = 1;
        m_idle_at = cyc + 1 + IFG;
      end
    end
    @(posedge rx_clk);
    #1;
    cyc++;
    e_start = (w != 0);
    e_ack   = (w == 3);
    e_abort = nab;
    if (w != 0) m_sel = w;
    e_busy = e_start || m_open || (cyc < m_idle_at);
    e_sel  = (e_start || m_open) ? m_sel : 0;
    check_all();
    ip_pkt_end = 1'b0;
    tx_done = 1'b0;
    if (e_ack) udp_tx_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ip_pkt_end = 1'b0;
    udp_tx_req = 1'b0;
    tx_done = 1'b0;
    #1;
    m_arp = 0; m_ip = 0; m_last_ip = 0; m_open = 0; m_drops = 0; m_sel = 0;
    m_idle_at = 0;
    e_start = 0; e_ack = 0; e_abort = 0; e_busy = 0; e_sel = 0;
    check_all();
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pkt(input logic [15:0] t);
    ip_pkt_end = 1'b1;
    ip_prot_type = t;
    step();
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    step();
  endtask

  task automatic wait_open();
    int k;
    k = 0;
    while (!m_open && k < 100) begin
      step();
      k++;
    end
    if (!m_open) begin
      total++;
      bad++;
      $display("FAIL wait_open no frame within %0d cycles", k);
    end
  endtask

  // Serve every outstanding request, finishing each frame a few cycles in.
  task automatic drain();
    int k;
    k = 0;
    while (!(model_idle() && !m_arp && !m_ip && !udp_tx_req) && k < 400) begin
      tx_done = m_open && (cyc - m_t0 == 3);
      step();
      k++;
    end
    if (k >= 400) begin
      total++;
      bad++;
      $display("FAIL drain scheduler not idle after %0d cycles", k);
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    do_reset();
    idle(9);
    pkt(16'h0806);
    idle(8);
    done_pulse();
    idle(15);

    udp_tx_req = 1'b1;
    pkt(16'h0800);
    drain();

    udp_tx_req = 1'b1;
    pkt(16'h0800);
    wait_open();
    pkt(16'h0806);
    idle(2);
    done_pulse();
    drain();

    pkt(16'h0806);
    udp_tx_req = 1'b1;
    wait_open();
    idle(20);
    drain();

    pkt(16'h0806);
    wait_open();
    pkt(16'h0800);
    pkt(16'h0800);
    pkt(16'h0800);
    done_pulse();
    drain();

    pkt(16'h0806);
    pkt(16'h0806);
    drain();

    done_pulse();
    idle(2);
    pkt(16'h0806);
    wait_open();
    idle(2);
    do_reset();
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ip_pkt_end = 1'b1;
        case ($urandom_range(0, 2))
          0: ip_prot_type = 16'h0800;
          1: ip_prot_type = 16'h0806;
          default: ip_prot_type = 16'($urandom);
        endcase
      end
      if (!udp_tx_req && $urandom_range(0, 15) == 0) udp_tx_req = 1'b1;
      tx_done = ($urandom_range(0, 9) == 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
